// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit: upstream instruction, registered result and data-cache handshake.
// The unit itself connects through the slave modport; the driving side uses master.
interface mem_access_unit_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int OFF_W  = 6,
    parameter int WSEL_W = 4
);
    logic                    in_valid;
    logic [ADDR_W-1:0]       in_addr;
    logic [4:0]              in_regd;
    logic [10:0]             in_opc;
    logic                    in_is_store;
    logic [2:0]              in_size;
    logic [DATA_W-1:0]       in_store_data;
    logic                    mem_ready;

    logic                    out_valid;
    logic [ADDR_W-1:0]       out_alures;
    logic [DATA_W-1:0]       out_load_data;
    logic [4:0]              out_regd;
    logic [10:0]             out_opc;
    logic [1:0]              mem_err;

    logic                    dc_req;
    logic [ADDR_W-OFF_W-1:0] dc_line_addr;
    logic [WSEL_W-1:0]       dc_word_select;
    logic [DATA_W/8-1:0]     dc_byte_mask;
    logic [DATA_W-1:0]       dc_data_to_cache;
    logic                    dc_read_write_n;
    logic                    dc_ack;
    logic [DATA_W-1:0]       dc_data_from_cache;

    modport slave (
        input  in_valid, in_addr, in_regd, in_opc, in_is_store, in_size, in_store_data,
        input  dc_ack, dc_data_from_cache,
        output mem_ready, out_valid, out_alures, out_load_data, out_regd, out_opc, mem_err,
        output dc_req, dc_line_addr, dc_word_select, dc_byte_mask, dc_data_to_cache, dc_read_write_n
    );

    modport master (
        output in_valid, in_addr, in_regd, in_opc, in_is_store, in_size, in_store_data,
        output dc_ack, dc_data_from_cache,
        input  mem_ready, out_valid, out_alures, out_load_data, out_regd, out_opc, mem_err,
        input  dc_req, dc_line_addr, dc_word_select, dc_byte_mask, dc_data_to_cache, dc_read_write_n
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: forwards ALU ops, issues aligned loads/stores to the data cache.
// Optional watchdog on the cache wait is enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int OFF_W   = 6,
    parameter int WSEL_W  = 4,
    parameter int TIMEOUT = 255
) (
    input logic              clk,
    input logic              reset,
    mem_access_unit_if.slave bus
);
    localparam int BYTES  = DATA_W / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam logic [10:0] BUBBLE_OPC = {2'b00, 3'b100, 6'b000000};

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                  state_q;

    logic                    outValid_q;
    logic [ADDR_W-1:0]       outAlures_q;
    logic [DATA_W-1:0]       outLoadData_q;
    logic [4:0]              outRegd_q;
    logic [10:0]             outOpc_q;
    logic [1:0]              memErr_q;

    logic                    dcReq_q;
    logic [ADDR_W-OFF_W-1:0] dcLineAddr_q;
    logic [WSEL_W-1:0]       dcWordSel_q;
    logic [BYTES-1:0]        dcByteMask_q;
    logic [DATA_W-1:0]       dcData_q;
    logic                    dcReadWriteN_q;

    logic [4:0]              pendRegd_q;
    logic [10:0]             pendOpc_q;
    logic [1:0]              pendSize_q;
    logic                    pendSigned_q;
    logic [LANE_W-1:0]       pendLane_q;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0]         wdog_q;
`endif

    logic [LANE_W-1:0]       laneIn;
    logic                    isMemOp;
    logic                    misaligned;
    logic [BYTES-1:0]        baseMask;
    logic [BYTES-1:0]        storeMask;
    logic [DATA_W-1:0]       storeData;
    logic [DATA_W-1:0]       shiftedRd;
    logic [DATA_W-1:0]       loadData;
    logic                    signBit;
    int                      loadBits;

    // Request decode: an access is misaligned if any lane bit below its size is set,
    // or if it is wider than one cache word.
    always_comb begin
        laneIn     = bus.in_addr[LANE_W-1:0];
        isMemOp    = (bus.in_opc[10:9] == 2'b01);
        misaligned = ((1 << bus.in_size[1:0]) > BYTES);
        for (int i = 0; i < LANE_W; i++) begin
            if ((i < int'(bus.in_size[1:0])) && laneIn[i]) misaligned = 1'b1;
        end
        for (int i = 0; i < BYTES; i++) begin
            baseMask[i] = (i < (1 << bus.in_size[1:0]));
        end
        storeMask = baseMask << laneIn;
        storeData = bus.in_store_data << {laneIn, 3'b000};
    end

    // Load return path: pick the field at the pending lane and extend it to full width.
    always_comb begin
        loadBits = 8 << pendSize_q;
        if (loadBits > DATA_W) loadBits = DATA_W;
        shiftedRd = bus.dc_data_from_cache >> {pendLane_q, 3'b000};
        signBit   = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == loadBits - 1) signBit = shiftedRd[i];
        end
        signBit = signBit & pendSigned_q;
        for (int i = 0; i < DATA_W; i++) begin
            loadData[i] = (i < loadBits) ? shiftedRd[i] : signBit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            outValid_q     <= 1'b0;
            outAlures_q    <= '0;
            outLoadData_q  <= '0;
            outRegd_q      <= '0;
            outOpc_q       <= BUBBLE_OPC;
            memErr_q       <= 2'b00;
            dcReq_q        <= 1'b0;
            dcLineAddr_q   <= '0;
            dcWordSel_q    <= '0;
            dcByteMask_q   <= '0;
            dcData_q       <= '0;
            dcReadWriteN_q <= 1'b1;
            pendRegd_q     <= '0;
            pendOpc_q      <= BUBBLE_OPC;
            pendSize_q     <= '0;
            pendSigned_q   <= 1'b0;
            pendLane_q     <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            wdog_q         <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    outValid_q    <= 1'b0;
                    outRegd_q     <= '0;
                    outOpc_q      <= BUBBLE_OPC;
                    memErr_q      <= 2'b00;
                    outLoadData_q <= '0;
                    if (bus.in_valid) begin
                        outAlures_q <= bus.in_addr;
                        if (!isMemOp) begin
                            outValid_q <= 1'b1;
                            outRegd_q  <= bus.in_regd;
                            outOpc_q   <= bus.in_opc;
                        end else if (misaligned) begin
                            outValid_q <= 1'b1;
                            outOpc_q   <= bus.in_opc;
                            memErr_q   <= 2'b01;
                        end else begin
                            dcReq_q        <= 1'b1;
                            dcLineAddr_q   <= bus.in_addr[ADDR_W-1:OFF_W];
                            dcWordSel_q    <= bus.in_addr[OFF_W-1:OFF_W-WSEL_W];
                            dcByteMask_q   <= bus.in_is_store ? storeMask : '0;
                            dcData_q       <= bus.in_is_store ? storeData : '0;
                            dcReadWriteN_q <= ~bus.in_is_store;
                            pendRegd_q     <= bus.in_regd;
                            pendOpc_q      <= bus.in_opc;
                            pendSize_q     <= bus.in_size[1:0];
                            pendSigned_q   <= bus.in_size[2];
                            pendLane_q     <= laneIn;
                            state_q        <= WAIT;
`ifdef MEM_ACCESS_TIMEOUT_EN
                            wdog_q         <= '0;
`endif
                        end
                    end
                end
                WAIT: begin
                    // An acknowledge wins over a watchdog expiry in the same cycle.
                    if (bus.dc_ack) begin
                        dcReq_q       <= 1'b0;
                        state_q       <= IDLE;
                        outValid_q    <= 1'b1;
                        outRegd_q     <= pendRegd_q;
                        outOpc_q      <= pendOpc_q;
                        memErr_q      <= 2'b00;
                        outLoadData_q <= dcReadWriteN_q ? loadData : '0;
                    end
`ifdef MEM_ACCESS_TIMEOUT_EN
                    else if (wdog_q == WD_LAST) begin
                        dcReq_q       <= 1'b0;
                        state_q       <= IDLE;
                        outValid_q    <= 1'b1;
                        outRegd_q     <= '0;
                        outOpc_q      <= pendOpc_q;
                        memErr_q      <= 2'b10;
                        outLoadData_q <= '0;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

    assign bus.mem_ready        = (state_q == IDLE);
    assign bus.out_valid        = outValid_q;
    assign bus.out_alures       = outAlures_q;
    assign bus.out_load_data    = outLoadData_q;
    assign bus.out_regd         = outRegd_q;
    assign bus.out_opc          = outOpc_q;
    assign bus.mem_err          = memErr_q;
    assign bus.dc_req           = dcReq_q;
    assign bus.dc_line_addr     = dcLineAddr_q;
    assign bus.dc_word_select   = dcWordSel_q;
    assign bus.dc_byte_mask     = dcByteMask_q;
    assign bus.dc_data_to_cache = dcData_q;
    assign bus.dc_read_write_n  = dcReadWriteN_q;
endmodule
